// File: rtl/nios_system_avalon_st_channel_filter_pkg.sv
// ============================================================================
// nios_system_avalon_st_channel_filter_pkg
// Shared filter FSM encodings and channel-width default.
// Rev 1.0
// ============================================================================
`default_nettype none

package nios_system_avalon_st_channel_filter_pkg;

    localparam int unsigned c_CHANNEL_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } filt_state_e;

endpackage

`default_nettype wire

// File: rtl/nios_system_avalon_st_skid_buffer.sv
// ============================================================================
// nios_system_avalon_st_skid_buffer
// Two-entry registered ready/valid stage: output register plus one skid slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module nios_system_avalon_st_skid_buffer #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             ready_o,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             ready_q, ready_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop_ready_i) begin
            // Output slot frees up: the skid entry is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = push_valid_i;
                if (push_valid_i) begin
                    skid_data_d = push_data_i;
                end
            end else begin
                out_valid_d = push_valid_i;
                if (push_valid_i) begin
                    out_data_d = push_data_i;
                end
            end
        end else if (push_valid_i) begin
            skid_valid_d = 1'b1;
            skid_data_d  = push_data_i;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

endmodule

`default_nettype wire

// File: rtl/nios_system_avalon_st_channel_filter.sv
// ============================================================================
// nios_system_avalon_st_channel_filter
// Forwards packets of one selected channel, discards the rest, counts drops.
// Rev 1.0
// ============================================================================
`default_nettype none

module nios_system_avalon_st_channel_filter
    import nios_system_avalon_st_channel_filter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ERROR_W     = 6,
    parameter int CHANNEL_W   = c_CHANNEL_W_DEFAULT,
    parameter int SEL_CHANNEL = 0,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [ERROR_W-1:0]   in_error,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic [CHANNEL_W-1:0] in_channel,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [ERROR_W-1:0]   out_error,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int                   c_W   = DATA_W + ERROR_W + 2;
    localparam logic [CHANNEL_W-1:0] c_SEL = CHANNEL_W'(SEL_CHANNEL);

    filt_state_e          state_q, state_d;
    logic [CNT_W-1:0]     drop_count_q, drop_count_d;
    logic                 w_accept;
    logic                 w_fwd;
    logic                 w_drop_inc;
    logic                 w_buf_ready;
    logic [c_W-1:0]       w_buf_data;

    assign w_accept = in_valid && w_buf_ready;

    always_comb begin
        state_d    = state_q;
        w_fwd      = 1'b0;
        w_drop_inc = 1'b0;
        if (w_accept) begin
            if (in_startofpacket) begin
                // Any SOP opens a new packet regardless of the current state.
                w_fwd      = (in_channel == c_SEL);
                w_drop_inc = !w_fwd;
                if (in_endofpacket) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = w_fwd ? ST_PASS : ST_DROP;
                end
            end else begin
                unique case (state_q)
                    ST_PASS: begin
                        w_fwd = 1'b1;
                        if (in_endofpacket) state_d = ST_IDLE;
                    end
                    ST_DROP: begin
                        if (in_endofpacket) state_d = ST_IDLE;
                    end
                    default: begin
                        w_drop_inc = 1'b1;
                        state_d    = ST_IDLE;
                    end
                endcase
            end
        end
        drop_count_d = drop_count_q;
        if (w_drop_inc && (drop_count_q != {CNT_W{1'b1}})) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_count_q <= drop_count_d;
        end
    end

    nios_system_avalon_st_skid_buffer #(
        .WIDTH (c_W)
    ) u_skid (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_valid_i (w_accept && w_fwd),
        .push_data_i  ({in_data, in_error, in_startofpacket, in_endofpacket}),
        .ready_o      (w_buf_ready),
        .pop_ready_i  (out_ready),
        .valid_o      (out_valid),
        .data_o       (w_buf_data)
    );

    assign in_ready   = w_buf_ready;
    assign drop_count = drop_count_q;
    assign {out_data, out_error, out_startofpacket, out_endofpacket} = w_buf_data;

endmodule

`default_nettype wire

// File: tb/tb_nios_system_avalon_st_channel_filter.sv
// ============================================================================
// tb_nios_system_avalon_st_channel_filter
// Directed and randomized checks against a packet-level reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nios_system_avalon_st_channel_filter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic [5:0]  in_error;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_channel;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_error;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    nios_system_avalon_st_channel_filter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_channel        (in_channel),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .drop_count        (drop_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [39:0] exp_q[$];
    bit          pkt_open;
    bit          pkt_keep;
    int unsigned exp_drops;
    bit          acc_flag;
    bit          rand_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] out_beat();
        return {out_data, out_error, out_startofpacket, out_endofpacket};
    endfunction

    function automatic void count_drop();
        if (exp_drops < 32'd65535) exp_drops++;
    endfunction

    // A beat is forwarded iff the SOP opening its packet carried channel 0.
    function automatic void model_accept();
        logic [39:0] b;
        b = {in_data, in_error, in_startofpacket, in_endofpacket};
        if (in_startofpacket) begin
            pkt_keep = (in_channel == 2'd0);
            pkt_open = !in_endofpacket;
            if (pkt_keep) exp_q.push_back(b);
            else          count_drop();
        end else if (!pkt_open) begin
            count_drop();
        end else begin
            if (pkt_keep) exp_q.push_back(b);
            if (in_endofpacket) pkt_open = 1'b0;
        end
    endfunction

    task automatic cycle();
        bit          hold_now;
        logic [39:0] held_now;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc_flag = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("out_beat", 64'(out_beat()), 64'(exp_q.pop_front()));
        end
        hold_now = out_valid && !out_ready;
        held_now = out_beat();
        if (acc_flag) model_accept();
        @(posedge clk);
        #1;
        if (hold_now) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_beat()), 64'(held_now));
        end
        chk("drop_count", 64'(drop_count), 64'(exp_drops));
    endtask

    task automatic drive(input logic [31:0] d, input bit sop, input bit eop, input logic [1:0] ch);
        in_data          = d;
        in_error         = 6'($urandom);
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_channel       = ch;
        in_valid         = 1'b1;
    endtask

    task automatic send(input logic [31:0] d, input bit sop, input bit eop, input logic [1:0] ch);
        bit ok;
        ok = 1'b0;
        drive(d, sop, eop, ch);
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (acc_flag) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("accept_in_time", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            cycle();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_idle", 64'(out_valid), 64'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pkt_open  = 1'b0;
        pkt_keep  = 1'b0;
        exp_drops = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_error         = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_channel       = '0;
        out_ready        = 1'b1;
        rand_ready       = 1'b0;
        model_reset();

        // Reset state and ready rising one edge after release
        repeat (5) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_out_payload", 64'(out_beat()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);

        // 4-beat ch0 packet with latency-1 check
        for (int i = 1; i <= 4; i++) begin
            send(32'h11 * i, i == 1, i == 4, 2'd0);
            chk("lat_valid", 64'(out_valid), 64'd1);
            chk("lat_data", 64'(out_data), 64'h11 * i);
        end
        drain();

        // ch2 packet dropped, ch0 packet back-to-back passes
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(32'hA0 + i, i == 0, i == 2, 2'd2);
            chk("drop_in_ready", 64'(in_ready), 64'd1);
        end
        for (int i = 0; i < 2; i++) begin
            send(32'hB0 + i, i == 0, i == 1, 2'd0);
            chk("pass_in_ready", 64'(in_ready), 64'd1);
        end
        drain();
        chk("drop_one_pkt", 64'(drop_count), 64'd1);

        // Backpressure: two beats fill the stage, third is held off
        out_ready = 1'b0;
        drive(32'hC1, 1'b1, 1'b0, 2'd0);
        cycle();
        chk("bp_acc1", 64'(acc_flag), 64'd1);
        drive(32'hC2, 1'b0, 1'b0, 2'd0);
        cycle();
        chk("bp_acc2", 64'(acc_flag), 64'd1);
        drive(32'hC3, 1'b0, 1'b1, 2'd0);
        cycle();
        chk("bp_acc3_blocked", 64'(acc_flag), 64'd0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (3) cycle();
        chk("bp_still_blocked", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (acc_flag) break;
        end
        in_valid = 1'b0;
        drain();

        // Orphan beat, then SOP-in-PASS restarting on a dropped channel
        do_reset();
        send(32'hD0, 1'b0, 1'b0, 2'd0);
        chk("orphan_drop", 64'(drop_count), 64'd1);
        send(32'hD1, 1'b1, 1'b0, 2'd0);
        send(32'hD2, 1'b0, 1'b0, 2'd3);
        send(32'hD3, 1'b1, 1'b0, 2'd3);
        send(32'hD4, 1'b0, 1'b1, 2'd0);
        send(32'hD5, 1'b1, 1'b1, 2'd0);
        drain();
        chk("restart_drop", 64'(drop_count), 64'd2);

        // Randomized packets, orphans and truncated packets with random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int  len;
            bit  trunc;
            logic [1:0] ch;
            len   = $urandom_range(1, 5);
            trunc = ($urandom_range(0, 5) == 0);
            ch    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) send($urandom, 1'b0, $urandom_range(0, 1) == 1, ch);
            for (int b = 0; b < len; b++) begin
                send($urandom, b == 0, (b == len - 1) && !trunc, 2'($urandom));
                if ($urandom_range(0, 3) == 0) cycle();
            end
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Asynchronous reset mid-packet with buffered beats
        out_ready = 1'b0;
        send(32'hE1, 1'b1, 1'b0, 2'd0);
        send(32'hE2, 1'b0, 1'b0, 2'd0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_payload", 64'(out_beat()), 64'd0);
        chk("arst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'hF1, 1'b1, 1'b0, 2'd0);
        send(32'hF2, 1'b0, 1'b1, 2'd0);
        drain();

        // Saturate the drop counter with continuous orphan beats
        drive(32'h0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 65540; i++) cycle();
        in_valid = 1'b0;
        cycle();
        chk("drop_saturated", 64'(drop_count), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
